grid_scan_driver: RTL and testbench

GRID_SCAN_DRIVER -- requirements
Module: grid_scan_driver

---
 rtl/grid_scan_driver.sv | 149 ++++++++++++++
 tb/tb_grid_scan_driver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/grid_scan_driver.sv
// Row-multiplexed scan driver for a 7x7 cell grid.
// Each frame snapshots the grid once (LATCH), then drives each row for DWELL
// cycles followed by BLANK all-off cycles. An optional blinking cursor is
// overlaid on the driven row using live cursor inputs.
// All state changes on the falling edge of clka.
module grid_scan_driver #(
    parameter int unsigned DWELL        = 1000,
    parameter int unsigned BLANK        = 16,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic        clka,
    input  logic        rst_n,
    input  logic        en,
    input  logic [48:0] grid,
    input  logic        cursor_en,
    input  logic [5:0]  cursor_idx,
    output logic [6:0]  row_sel,
    output logic [6:0]  col_data,
    output logic        frame_start
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLatch = 2'd1;
    localparam logic [1:0] StDwell = 2'd2;
    localparam logic [1:0] StBlnk  = 2'd3;

    localparam logic [15:0] DwellLast = 16'(DWELL - 1);
    localparam logic [15:0] BlankLast = 16'(BLANK - 1);
    localparam logic [7:0]  BlinkLast = 8'(BLINK_FRAMES - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  row_q, row_d;
    logic [15:0] cnt_q, cnt_d;
    logic [48:0] frame_buf_q, frame_buf_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        blink_q, blink_d;

    logic [6:0]  row_sel_d, col_data_d;
    logic        frame_start_d;
    logic [6:0]  row_bits;
    logic [2:0]  cur_row, cur_col;

    // Scan sequencing: state, current row and the shared dwell/blank counter.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = StIdle;
            row_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: state_d = StLatch;
                StLatch: begin
                    state_d = StDwell;
                    row_d   = '0;
                    cnt_d   = '0;
                end
                StDwell: begin
                    if (cnt_q == DwellLast) begin
                        state_d = StBlnk;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StBlnk: begin
                    if (cnt_q == BlankLast) begin
                        cnt_d = '0;
                        if (row_q == 3'd6) begin
                            state_d = StLatch;
                        end else begin
                            state_d = StDwell;
                            row_d   = row_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Frame snapshot and blink timebase, both advanced only in a LATCH cycle.
    always_comb begin
        frame_buf_d = frame_buf_q;
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (en && state_q == StLatch) begin
            frame_buf_d = grid;
            if (frame_cnt_q == BlinkLast) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    // Registered outputs are computed from the state being entered, so the
    // first DWELL cycle already sees the fresh snapshot and blink phase.
    always_comb begin
        row_bits = '0;
        for (int r = 0; r < 7; r++) begin
            if (row_d == 3'(r)) row_bits = frame_buf_d[7*r +: 7];
        end
        // Truncation is harmless: only used when cursor_idx <= 48.
        cur_row = 3'(cursor_idx / 6'd7);
        cur_col = 3'(cursor_idx % 6'd7);
        if (cursor_en && cursor_idx <= 6'd48 && cur_row == row_d) begin
            row_bits[cur_col] = blink_d;
        end
        row_sel_d     = '0;
        col_data_d    = '0;
        frame_start_d = (state_d == StLatch);
        if (state_d == StDwell) begin
            row_sel_d  = 7'd1 << row_d;
            col_data_d = row_bits;
        end
    end

    // State and output registers, falling-edge clocked with async reset.
    always_ff @(negedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            row_q       <= '0;
            cnt_q       <= '0;
            frame_buf_q <= '0;
            frame_cnt_q <= '0;
            blink_q     <= 1'b1;
            row_sel     <= '0;
            col_data    <= '0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            frame_buf_q <= frame_buf_d;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
            row_sel     <= row_sel_d;
            col_data    <= col_data_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_grid_scan_driver.sv
// Directed bench for grid_scan_driver with DWELL=4, BLANK=2, BLINK_FRAMES=2.
// DUT updates on the falling edge; the bench drives and samples on the rising edge.
module tb_grid_scan_driver;

    localparam int unsigned DW = 4;
    localparam int unsigned BL = 2;
    localparam int unsigned BF = 2;

    logic        clka = 1'b1;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [48:0] grid = '0;
    logic        cursor_en = 1'b0;
    logic [5:0]  cursor_idx = '0;
    logic [6:0]  row_sel;
    logic [6:0]  col_data;
    logic        frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    grid_scan_driver #(
        .DWELL        (DW),
        .BLANK        (BL),
        .BLINK_FRAMES (BF)
    ) dut (
        .clka        (clka),
        .rst_n       (rst_n),
        .en          (en),
        .grid        (grid),
        .cursor_en   (cursor_en),
        .cursor_idx  (cursor_idx),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_start (frame_start)
    );

    always #5 clka = ~clka;

    typedef struct {
        logic [48:0]     grid;
        logic            cen;
        logic [5:0]      cidx;
        logic [6:0][6:0] rows;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next rising edge that shows frame_start; n = edges waited.
    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(posedge clka);
            n++;
        end while (frame_start !== 1'b1 && n < 200);
        check("frame_start_seen", {31'b0, frame_start}, 32'd1);
    endtask

    // Check the 42 cycles after a frame_start; optionally change grid mid-frame.
    task automatic check_frame(input string name, input logic [6:0][6:0] exp,
                               input int chg_at, input logic [48:0] chg_grid);
        int r;
        int d;
        for (int k = 0; k < 42; k++) begin
            r = k / 6;
            d = k % 6;
            @(posedge clka);
            check({name, "_row_sel"}, {25'b0, row_sel}, (d < 4) ? (32'd1 << r) : 32'd0);
            check({name, "_col_data"}, {25'b0, col_data}, (d < 4) ? {25'b0, exp[r]} : 32'd0);
            check({name, "_frame_start"}, {31'b0, frame_start}, 32'd0);
            if (k == chg_at) grid = chg_grid;
        end
    endtask

    localparam logic [6:0][6:0] Pat = {7'b0101010, 7'b1010101, 7'b1100110, 7'b0011001,
                                       7'b1110000, 7'b0001111, 7'b1001001};
    localparam logic [6:0][6:0] Zero = '0;
    localparam logic [6:0][6:0] Ones = '1;

    initial begin
        int n;
        logic [6:0][6:0] exp_rows;
        logic phase_tab [6];

        vecs[0] = '{grid: 49'h1000000000001, cen: 1'b0, cidx: 6'd0,
                    rows: {7'b1000000, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0000001}};
        vecs[1] = '{grid: '1, cen: 1'b0, cidx: 6'd10, rows: Ones};
        vecs[2] = '{grid: Pat, cen: 1'b1, cidx: 6'd55, rows: Pat};
        vecs[3] = '{grid: '0, cen: 1'b0, cidx: 6'd10, rows: Zero};
        vecs[4] = '{grid: 49'h400, cen: 1'b1, cidx: 6'd49,
                    rows: {7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0001000, 7'b0}};
        phase_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clka);
        check("rst_row_sel", {25'b0, row_sel}, 32'd0);
        check("rst_col_data", {25'b0, col_data}, 32'd0);
        check("rst_frame_start", {31'b0, frame_start}, 32'd0);

        // Blinking cursor at cell 10 (row 1, column 3) on an empty grid
        grid = '0;
        cursor_en = 1'b1;
        cursor_idx = 6'd10;
        en = 1'b1;
        rst_n = 1'b1;
        for (int f = 0; f < 6; f++) begin
            wait_fs(n);
            check("frame_period", n, 32'd1);
            exp_rows = '0;
            exp_rows[1] = phase_tab[f] ? 7'b0001000 : 7'b0;
            check_frame("blink", exp_rows, -1, '0);
        end

        // Frame 7 has phase 0; reset mid-DWELL must clear outputs at once
        wait_fs(n);
        check("frame_period_f7", n, 32'd1);
        repeat (7) @(posedge clka);
        check("f7_row_sel", {25'b0, row_sel}, 32'd2);
        check("f7_col_data", {25'b0, col_data}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_row_sel", {25'b0, row_sel}, 32'd0);
        check("async_rst_col_data", {25'b0, col_data}, 32'd0);
        repeat (2) @(posedge clka);
        check("held_rst_row_sel", {25'b0, row_sel}, 32'd0);
        check("held_rst_frame_start", {31'b0, frame_start}, 32'd0);
        rst_n = 1'b1;
        wait_fs(n);
        check("first_latch_after_rst", n, 32'd1);
        exp_rows = '0;
        exp_rows[1] = 7'b0001000;
        check_frame("blink_after_rst", exp_rows, -1, '0);

        // Table vectors
        for (int i = 0; i < 5; i++) begin
            grid = vecs[i].grid;
            cursor_en = vecs[i].cen;
            cursor_idx = vecs[i].cidx;
            wait_fs(n);
            check("vec_period", n, 32'd1);
            check_frame($sformatf("vec%0d", i), vecs[i].rows, -1, '0);
        end

        // Grid change during row 3 DWELL must not tear the frame
        grid = '0;
        cursor_en = 1'b0;
        wait_fs(n);
        check_frame("tear_old", Zero, 19, '1);
        wait_fs(n);
        check("tear_period", n, 32'd1);
        check_frame("tear_new", Ones, -1, '0);

        // en dropped in row 2 DWELL, raised 5 cycles later
        grid = Pat;
        wait_fs(n);
        repeat (14) @(posedge clka);
        check("pre_drop_row_sel", {25'b0, row_sel}, 32'd4);
        check("pre_drop_col_data", {25'b0, col_data}, {25'b0, Pat[2]});
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clka);
            check("idle_row_sel", {25'b0, row_sel}, 32'd0);
            check("idle_col_data", {25'b0, col_data}, 32'd0);
            check("idle_frame_start", {31'b0, frame_start}, 32'd0);
        end
        en = 1'b1;
        wait_fs(n);
        check("restart_latch", n, 32'd1);
        check_frame("restart", Pat, -1, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
